llc_snoop_responder: RTL and testbench

- Responder end of the LLC snooping bus protocol. Accepts bus operations issued by other caches, looks up this LLC's MESI state for the addressed line, and returns a snoop result (NOHIT/HIT/HITM).
- Issues the required L2->L1 messages (GETLINE, INVALIDATELINE), drives a dirty-line writeback on the bus, and commits the next MESI state.
- Sits between the shared bus model and the LLC tag/state array.

---
 rtl/llc_snoop_responder_pkg.sv | 67 ++++++
 rtl/llc_snoop_responder_snoop_action_decode.sv | 86 ++++++++
 rtl/llc_snoop_responder.sv | 189 ++++++++++++++++++
 tb/tb_llc_snoop_responder.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_snoop_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | llc_snoop_responder_pkg                                              |
// | Shared MESI, bus-message and L2->L1 types for the snoop responder.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package llc_snoop_responder_pkg;

  typedef enum logic [1:0] {
    INVALID   = 2'b00,
    SHARED    = 2'b01,
    EXCLUSIVE = 2'b10,
    MODIFIED  = 2'b11
  } mesi_e;

  typedef enum logic [2:0] {
    READ       = 3'd1,
    WRITE      = 3'd2,
    INVALIDATE = 3'd3,
    RWIM       = 3'd4
  } bus_operation_e;

  // operation is kept as raw bits so undefined opcodes survive the trip
  typedef struct packed {
    logic [2:0]  operation;
    logic [31:0] address;
    logic [3:0]  cache_id;
  } bus_msg_st;

  typedef enum logic [1:0] {
    NOHIT = 2'd0,
    HIT   = 2'd1,
    HITM  = 2'd2
  } snoop_result_e;

  typedef enum logic [2:0] {
    L1_NONE        = 3'd0,
    GETLINE        = 3'd1,
    SENDLINE       = 3'd2,
    INVALIDATELINE = 3'd3,
    EVICTLINE      = 3'd4
  } l2_l1_msg_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_WAIT    = 3'd2,
    S_RESPOND = 3'd3,
    S_L1_GET  = 3'd4,
    S_WB      = 3'd5,
    S_L1_INV  = 3'd6,
    S_UPDATE  = 3'd7
  } snp_state_e;

  localparam int C_DEFAULT_OFFSET_BITS = 6;

  function automatic logic [31:0] line_addr(input logic [31:0] addr,
                                            input int offset_bits = C_DEFAULT_OFFSET_BITS);
    logic [31:0] mask;
    mask = '1;
    mask = mask << offset_bits;
    return addr & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/llc_snoop_responder_snoop_action_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snoop_action_decode                                                  |
// | Maps {bus op, current MESI} to snoop result and follow-up actions.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module snoop_action_decode
  import llc_snoop_responder_pkg::*;
(
  input  logic [2:0]    i_op,
  input  mesi_e         i_state,
  output snoop_result_e o_result,
  output logic          o_need_get,
  output logic          o_need_wb,
  output logic          o_need_inv,
  output logic          o_do_update,
  output mesi_e         o_next_state,
  output logic          o_err
);

  always_comb begin
    o_result     = NOHIT;
    o_need_get   = 1'b0;
    o_need_wb    = 1'b0;
    o_need_inv   = 1'b0;
    o_do_update  = 1'b0;
    o_next_state = i_state;
    o_err        = 1'b0;
    case (i_op)
      READ: begin
        case (i_state)
          MODIFIED: begin
            o_result     = HITM;
            o_need_get   = 1'b1;
            o_need_wb    = 1'b1;
            o_do_update  = 1'b1;
            o_next_state = SHARED;
          end
          EXCLUSIVE, SHARED: begin
            o_result     = HIT;
            o_do_update  = 1'b1;
            o_next_state = SHARED;
          end
          default: ;
        endcase
      end
      RWIM: begin
        case (i_state)
          MODIFIED: begin
            o_result     = HITM;
            o_need_get   = 1'b1;
            o_need_wb    = 1'b1;
            o_need_inv   = 1'b1;
            o_do_update  = 1'b1;
            o_next_state = INVALID;
          end
          EXCLUSIVE, SHARED: begin
            o_result     = HIT;
            o_need_inv   = 1'b1;
            o_do_update  = 1'b1;
            o_next_state = INVALID;
          end
          default: ;
        endcase
      end
      INVALIDATE: begin
        case (i_state)
          SHARED: begin
            o_result     = HIT;
            o_need_inv   = 1'b1;
            o_do_update  = 1'b1;
            o_next_state = INVALID;
          end
          // Another cache cannot legally invalidate a line we own exclusively
          EXCLUSIVE, MODIFIED: o_err = 1'b1;
          default: ;
        endcase
      end
      WRITE: ;
      default: o_err = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/llc_snoop_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | llc_snoop_responder                                                  |
// | Snoop-side responder: lookup, result, L1 messages, writeback, update.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module llc_snoop_responder
  import llc_snoop_responder_pkg::*;
#(
  parameter int         ADDR_W      = 32,
  parameter int         OFFSET_BITS = 6,
  parameter logic [3:0] OWN_ID      = 4'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              snp_valid,
  output logic              snp_ready,
  input  bus_msg_st         snp_msg,
  output logic              lk_req,
  output logic [ADDR_W-1:0] lk_addr,
  input  logic              lk_ack,
  input  mesi_e             lk_state,
  output logic              sr_valid,
  input  logic              sr_ready,
  output snoop_result_e     sr_result,
  output logic [ADDR_W-1:0] sr_addr,
  output logic              l1_valid,
  input  logic              l1_ready,
  output l2_l1_msg_e        l1_msg,
  output logic [ADDR_W-1:0] l1_addr,
  output logic              wb_valid,
  input  logic              wb_ready,
  output bus_msg_st         wb_msg,
  output logic              st_wr,
  output logic [ADDR_W-1:0] st_addr,
  output mesi_e             st_state,
  output logic              err_protocol,
  output logic              busy
);

  snp_state_e    r_state;
  logic [2:0]    r_op;
  logic [31:0]   r_addr;
  logic          r_get, r_wb, r_inv, r_upd;
  mesi_e         r_new_state;
  logic          r_snp_ready, r_busy, r_lk_req, r_sr_valid, r_l1_valid, r_wb_valid;
  logic          r_st_wr, r_err;
  snoop_result_e r_sr_result;
  l2_l1_msg_e    r_l1_msg;
  bus_msg_st     r_wb_msg;
  mesi_e         r_st_state;

  snoop_result_e w_dec_result;
  logic          w_dec_get, w_dec_wb, w_dec_inv, w_dec_upd, w_dec_err;
  mesi_e         w_dec_next;
  logic [31:0]   w_line;
  logic          w_accept, w_bypass, w_ack;
  snp_state_e    w_nxt, w_after_sr, w_after_get, w_after_wb, w_after_inv;

  snoop_action_decode u_decode (
    .i_op         (r_op),
    .i_state      (lk_state),
    .o_result     (w_dec_result),
    .o_need_get   (w_dec_get),
    .o_need_wb    (w_dec_wb),
    .o_need_inv   (w_dec_inv),
    .o_do_update  (w_dec_upd),
    .o_next_state (w_dec_next),
    .o_err        (w_dec_err)
  );

  assign w_line   = line_addr(r_addr, OFFSET_BITS);
  assign w_accept = snp_valid && r_snp_ready && (r_state == S_IDLE);
  // Own snoops and plain writes never touch our copy of the line
  assign w_bypass = (snp_msg.cache_id == OWN_ID) || (snp_msg.operation == WRITE);
  // Only WAIT listens to the lookup port, so an early ack is dropped
  assign w_ack    = (r_state == S_WAIT) && lk_ack;

  always_comb begin
    w_after_inv = r_upd ? S_UPDATE : S_IDLE;
    w_after_wb  = r_inv ? S_L1_INV : w_after_inv;
    w_after_get = r_wb  ? S_WB     : w_after_wb;
    w_after_sr  = r_get ? S_L1_GET : w_after_get;
    w_nxt       = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_nxt = w_bypass ? S_RESPOND : S_LOOKUP;
      S_LOOKUP:  w_nxt = S_WAIT;
      S_WAIT:    if (lk_ack) w_nxt = S_RESPOND;
      S_RESPOND: if (sr_ready) w_nxt = w_after_sr;
      S_L1_GET:  if (l1_ready) w_nxt = w_after_get;
      S_WB:      if (wb_ready) w_nxt = w_after_wb;
      S_L1_INV:  if (l1_ready) w_nxt = w_after_inv;
      S_UPDATE:  w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each valid/strobe lines
  // up exactly with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_addr      <= '0;
      r_get       <= 1'b0;
      r_wb        <= 1'b0;
      r_inv       <= 1'b0;
      r_upd       <= 1'b0;
      r_new_state <= INVALID;
      r_snp_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_lk_req    <= 1'b0;
      r_sr_valid  <= 1'b0;
      r_l1_valid  <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_st_wr     <= 1'b0;
      r_err       <= 1'b0;
      r_sr_result <= NOHIT;
      r_l1_msg    <= L1_NONE;
      r_wb_msg    <= '0;
      r_st_state  <= INVALID;
    end else begin
      r_state     <= w_nxt;
      r_snp_ready <= (w_nxt == S_IDLE);
      r_busy      <= (w_nxt != S_IDLE);
      r_lk_req    <= (w_nxt == S_LOOKUP);
      r_sr_valid  <= (w_nxt == S_RESPOND);
      r_l1_valid  <= (w_nxt == S_L1_GET) || (w_nxt == S_L1_INV);
      r_wb_valid  <= (w_nxt == S_WB);
      r_st_wr     <= (w_nxt == S_UPDATE);
      r_err       <= 1'b0;

      if (w_accept) begin
        r_op        <= snp_msg.operation;
        r_addr      <= snp_msg.address;
        r_get       <= 1'b0;
        r_wb        <= 1'b0;
        r_inv       <= 1'b0;
        r_upd       <= 1'b0;
        r_new_state <= INVALID;
        r_sr_result <= NOHIT;
      end

      if (w_ack) begin
        r_get       <= w_dec_get;
        r_wb        <= w_dec_wb;
        r_inv       <= w_dec_inv;
        r_upd       <= w_dec_upd;
        r_new_state <= w_dec_next;
        r_sr_result <= w_dec_result;
        r_err       <= w_dec_err;
      end

      if (w_nxt == S_L1_GET) begin
        r_l1_msg <= GETLINE;
      end else if (w_nxt == S_L1_INV) begin
        r_l1_msg <= INVALIDATELINE;
      end

      if (w_nxt == S_WB) begin
        r_wb_msg <= {WRITE, w_line, OWN_ID};
      end

      if (w_nxt == S_UPDATE) begin
        r_st_state <= r_new_state;
      end
    end
  end

  assign snp_ready    = r_snp_ready;
  assign busy         = r_busy;
  assign lk_req       = r_lk_req;
  assign lk_addr      = w_line[ADDR_W-1:0];
  assign sr_valid     = r_sr_valid;
  assign sr_result    = r_sr_result;
  assign sr_addr      = r_addr[ADDR_W-1:0];
  assign l1_valid     = r_l1_valid;
  assign l1_msg       = r_l1_msg;
  assign l1_addr      = w_line[ADDR_W-1:0];
  assign wb_valid     = r_wb_valid;
  assign wb_msg       = r_wb_msg;
  assign st_wr        = r_st_wr;
  assign st_addr      = w_line[ADDR_W-1:0];
  assign st_state     = r_st_state;
  assign err_protocol = r_err;

endmodule

`default_nettype wire

// File: tb/tb_llc_snoop_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_llc_snoop_responder                                               |
// | Directed self-checking bench for the LLC snoop responder.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_llc_snoop_responder;
  import llc_snoop_responder_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          snp_valid, snp_ready;
  bus_msg_st     snp_msg;
  logic          lk_req, lk_ack;
  logic [31:0]   lk_addr, sr_addr, l1_addr, st_addr;
  mesi_e         lk_state, st_state;
  logic          sr_valid, sr_ready, l1_valid, l1_ready, wb_valid, wb_ready;
  snoop_result_e sr_result;
  l2_l1_msg_e    l1_msg;
  bus_msg_st     wb_msg;
  logic          st_wr, err_protocol, busy;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  llc_snoop_responder #(.ADDR_W(32), .OFFSET_BITS(6), .OWN_ID(4'd0)) dut (
    .clk(clk), .rst(rst),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_msg(snp_msg),
    .lk_req(lk_req), .lk_addr(lk_addr), .lk_ack(lk_ack), .lk_state(lk_state),
    .sr_valid(sr_valid), .sr_ready(sr_ready), .sr_result(sr_result), .sr_addr(sr_addr),
    .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_msg(l1_msg), .l1_addr(l1_addr),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_msg(wb_msg),
    .st_wr(st_wr), .st_addr(st_addr), .st_state(st_state),
    .err_protocol(err_protocol), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [3:0] id);
    snp_msg   = {op, a, id};
    snp_valid = 1'b1;
  endtask

  task automatic test_reset();
    nvec++;
    if ({snp_ready, busy, lk_req, sr_valid, l1_valid, wb_valid, st_wr, err_protocol} !== 8'b1000_0000) begin
      nerr++;
      $display("FAIL reset_ctrl got %b want 10000000",
               {snp_ready, busy, lk_req, sr_valid, l1_valid, wb_valid, st_wr, err_protocol});
    end
    nvec++;
    if ({lk_addr, sr_addr, l1_addr, st_addr} !== 128'd0 || wb_msg !== 39'd0 ||
        {sr_result, l1_msg, st_state} !== 7'd0) begin
      nerr++;
      $display("FAIL reset_data got lk=%h sr=%h l1=%h st=%h wb=%h res/msg/st=%h want all 0",
               lk_addr, sr_addr, l1_addr, st_addr, wb_msg, {sr_result, l1_msg, st_state});
    end
  endtask

  task automatic test_read_modified();
    bus_msg_st exp_wb;
    exp_wb   = {WRITE, 32'h0000_1040, 4'd0};
    sr_ready = 1'b1; l1_ready = 1'b1; wb_ready = 1'b1; lk_state = MODIFIED;
    present(READ, 32'h0000_1044, 4'd2);
    tick(); snp_valid = 1'b0;
    nvec++;
    if ({lk_req, snp_ready, busy} !== 3'b101 || lk_addr !== 32'h0000_1040) begin
      nerr++;
      $display("FAIL rdm_lookup req/rdy/busy=%b addr=%h want 101 00001040", {lk_req, snp_ready, busy}, lk_addr);
    end
    tick(); lk_ack = 1'b1;
    nvec++;
    if ({lk_req, sr_valid} !== 2'b00) begin
      nerr++;
      $display("FAIL rdm_wait req/srv=%b want 00", {lk_req, sr_valid});
    end
    tick(); lk_ack = 1'b0;
    nvec++;
    if (sr_valid !== 1'b1 || sr_result !== HITM || sr_addr !== 32'h0000_1044 || err_protocol !== 1'b0) begin
      nerr++;
      $display("FAIL rdm_result v=%b res=%0d addr=%h err=%b want 1 2 00001044 0", sr_valid, sr_result, sr_addr, err_protocol);
    end
    tick();
    nvec++;
    if ({sr_valid, l1_valid, wb_valid, st_wr} !== 4'b0100 || l1_msg !== GETLINE || l1_addr !== 32'h0000_1040) begin
      nerr++;
      $display("FAIL rdm_getline v=%b msg=%0d addr=%h want 0100 1 00001040", {sr_valid, l1_valid, wb_valid, st_wr}, l1_msg, l1_addr);
    end
    tick();
    nvec++;
    if ({sr_valid, l1_valid, wb_valid, st_wr} !== 4'b0010 || wb_msg !== exp_wb) begin
      nerr++;
      $display("FAIL rdm_writeback v=%b msg=%h want 0010 %h", {sr_valid, l1_valid, wb_valid, st_wr}, wb_msg, exp_wb);
    end
    tick();
    nvec++;
    if ({sr_valid, l1_valid, wb_valid, st_wr} !== 4'b0001 || st_addr !== 32'h0000_1040 || st_state !== SHARED) begin
      nerr++;
      $display("FAIL rdm_update v=%b addr=%h st=%0d want 0001 00001040 1", {sr_valid, l1_valid, wb_valid, st_wr}, st_addr, st_state);
    end
    tick();
    nvec++;
    if ({sr_valid, l1_valid, wb_valid, st_wr, snp_ready, busy} !== 6'b000010) begin
      nerr++;
      $display("FAIL rdm_idle v/rdy/busy=%b want 000010", {sr_valid, l1_valid, wb_valid, st_wr, snp_ready, busy});
    end
  endtask

  task automatic test_rwim_stall();
    int bad;
    sr_ready = 1'b0; l1_ready = 1'b1; wb_ready = 1'b1; lk_state = SHARED;
    present(RWIM, 32'h0000_2000, 4'd1);
    tick(); snp_valid = 1'b0;
    tick(); lk_ack = 1'b1;
    tick(); lk_ack = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (sr_valid !== 1'b1 || sr_result !== HIT || sr_addr !== 32'h0000_2000 || wb_valid !== 1'b0 || l1_valid !== 1'b0)
        bad++;
      if (i == 5) sr_ready = 1'b1;
      tick();
    end
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL rwim_hold unstable cycles=%0d want 0", bad);
    end
    nvec++;
    if ({sr_valid, l1_valid, wb_valid, st_wr} !== 4'b0100 || l1_msg !== INVALIDATELINE || l1_addr !== 32'h0000_2000) begin
      nerr++;
      $display("FAIL rwim_inv v=%b msg=%0d addr=%h want 0100 3 00002000", {sr_valid, l1_valid, wb_valid, st_wr}, l1_msg, l1_addr);
    end
    tick();
    nvec++;
    if ({l1_valid, wb_valid, st_wr} !== 3'b001 || st_state !== INVALID || st_addr !== 32'h0000_2000) begin
      nerr++;
      $display("FAIL rwim_update v=%b st=%0d addr=%h want 001 0 00002000", {l1_valid, wb_valid, st_wr}, st_state, st_addr);
    end
    tick();
    nvec++;
    if ({st_wr, snp_ready, busy} !== 3'b010) begin
      nerr++;
      $display("FAIL rwim_idle wr/rdy/busy=%b want 010", {st_wr, snp_ready, busy});
    end
  endtask

  task automatic test_invalidate_exclusive();
    int bad;
    sr_ready = 1'b1; l1_ready = 1'b1; wb_ready = 1'b1; lk_state = EXCLUSIVE;
    present(INVALIDATE, 32'h0000_3000, 4'd3);
    tick(); snp_valid = 1'b0;
    tick(); lk_ack = 1'b1;
    nvec++;
    if (err_protocol !== 1'b0) begin
      nerr++;
      $display("FAIL inv_err_early err=%b want 0", err_protocol);
    end
    tick(); lk_ack = 1'b0;
    nvec++;
    if (sr_valid !== 1'b1 || sr_result !== NOHIT || err_protocol !== 1'b1) begin
      nerr++;
      $display("FAIL inv_result v=%b res=%0d err=%b want 1 0 1", sr_valid, sr_result, err_protocol);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if ({err_protocol, st_wr, l1_valid, wb_valid, sr_valid} !== 5'b0) bad++;
    end
    nvec++;
    if (bad != 0 || snp_ready !== 1'b1) begin
      nerr++;
      $display("FAIL inv_quiet bad_cycles=%0d rdy=%b want 0 1", bad, snp_ready);
    end
  endtask

  task automatic test_self_snoop();
    sr_ready = 1'b1;
    present(READ, 32'h0000_5004, 4'd0);
    tick(); snp_valid = 1'b0;
    nvec++;
    if (lk_req !== 1'b0 || sr_valid !== 1'b1 || sr_result !== NOHIT || sr_addr !== 32'h0000_5004) begin
      nerr++;
      $display("FAIL self_result req=%b v=%b res=%0d addr=%h want 0 1 0 00005004", lk_req, sr_valid, sr_result, sr_addr);
    end
    tick();
    nvec++;
    if ({snp_ready, busy, lk_req, sr_valid, st_wr} !== 5'b10000) begin
      nerr++;
      $display("FAIL self_idle rdy/busy/req/v/wr=%b want 10000", {snp_ready, busy, lk_req, sr_valid, st_wr});
    end
  endtask

  task automatic test_bad_opcode();
    sr_ready = 1'b1; lk_state = SHARED;
    present(3'd6, 32'h0000_4000, 4'd1);
    tick(); snp_valid = 1'b0; lk_ack = 1'b1;
    tick(); lk_ack = 1'b0;
    tick();
    nvec++;
    if (sr_valid !== 1'b0 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL early_ack_ignored v=%b busy=%b want 0 1", sr_valid, busy);
    end
    lk_ack = 1'b1;
    tick(); lk_ack = 1'b0;
    nvec++;
    if (sr_valid !== 1'b1 || sr_result !== NOHIT || err_protocol !== 1'b1) begin
      nerr++;
      $display("FAIL badop_result v=%b res=%0d err=%b want 1 0 1", sr_valid, sr_result, err_protocol);
    end
    tick();
    nvec++;
    if ({err_protocol, st_wr, snp_ready} !== 3'b001) begin
      nerr++;
      $display("FAIL badop_done err/wr/rdy=%b want 001", {err_protocol, st_wr, snp_ready});
    end
  endtask

  task automatic test_reset_mid_wb();
    int wr_seen;
    sr_ready = 1'b1; l1_ready = 1'b1; wb_ready = 1'b0; lk_state = MODIFIED;
    wr_seen = 0;
    present(READ, 32'h0000_6010, 4'd2);
    tick(); snp_valid = 1'b0;
    tick(); lk_ack = 1'b1;
    tick(); lk_ack = 1'b0;
    tick();
    tick();
    tick();
    nvec++;
    if (wb_valid !== 1'b1 || wb_msg !== {WRITE, 32'h0000_6000, 4'd0}) begin
      nerr++;
      $display("FAIL rst_wb_stall v=%b msg=%h want 1 %h", wb_valid, wb_msg, {WRITE, 32'h0000_6000, 4'd0});
    end
    rst = 1'b1;
    tick(); rst = 1'b0; wb_ready = 1'b1;
    nvec++;
    if ({sr_valid, l1_valid, wb_valid, lk_req, st_wr, busy, snp_ready} !== 7'b0000001) begin
      nerr++;
      $display("FAIL rst_abandon v/req/wr/busy/rdy=%b want 0000001", {sr_valid, l1_valid, wb_valid, lk_req, st_wr, busy, snp_ready});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (st_wr !== 1'b0 || busy !== 1'b0) wr_seen++;
    end
    nvec++;
    if (wr_seen != 0) begin
      nerr++;
      $display("FAIL rst_no_update activity_cycles=%0d want 0", wr_seen);
    end
  endtask

  task automatic test_back_to_back();
    int rdy_hi;
    sr_ready = 1'b1; l1_ready = 1'b1; wb_ready = 1'b1; lk_state = INVALID;
    rdy_hi = 0;
    present(READ, 32'h0000_7000, 4'd2);
    tick();
    present(READ, 32'h0000_7084, 4'd3);
    if (snp_ready !== 1'b0) rdy_hi++;
    tick(); lk_ack = 1'b1;
    if (snp_ready !== 1'b0) rdy_hi++;
    tick(); lk_ack = 1'b0;
    if (snp_ready !== 1'b0) rdy_hi++;
    nvec++;
    if (sr_valid !== 1'b1 || sr_result !== NOHIT || sr_addr !== 32'h0000_7000) begin
      nerr++;
      $display("FAIL b2b_first v=%b res=%0d addr=%h want 1 0 00007000", sr_valid, sr_result, sr_addr);
    end
    nvec++;
    if (rdy_hi != 0) begin
      nerr++;
      $display("FAIL b2b_ready_low ready_high_cycles=%0d want 0", rdy_hi);
    end
    tick(); lk_state = EXCLUSIVE;
    nvec++;
    if ({snp_ready, st_wr, lk_req} !== 3'b100) begin
      nerr++;
      $display("FAIL b2b_gap rdy/wr/req=%b want 100", {snp_ready, st_wr, lk_req});
    end
    tick(); snp_valid = 1'b0;
    nvec++;
    if (lk_req !== 1'b1 || lk_addr !== 32'h0000_7080) begin
      nerr++;
      $display("FAIL b2b_lookup req=%b addr=%h want 1 00007080", lk_req, lk_addr);
    end
    tick(); lk_ack = 1'b1;
    tick(); lk_ack = 1'b0;
    nvec++;
    if (sr_valid !== 1'b1 || sr_result !== HIT || sr_addr !== 32'h0000_7084) begin
      nerr++;
      $display("FAIL b2b_second v=%b res=%0d addr=%h want 1 1 00007084", sr_valid, sr_result, sr_addr);
    end
    tick();
    nvec++;
    if ({st_wr, l1_valid, wb_valid} !== 3'b100 || st_state !== SHARED || st_addr !== 32'h0000_7080) begin
      nerr++;
      $display("FAIL b2b_update v=%b st=%0d addr=%h want 100 1 00007080", {st_wr, l1_valid, wb_valid}, st_state, st_addr);
    end
    tick();
    nvec++;
    if ({st_wr, snp_ready, busy} !== 3'b010) begin
      nerr++;
      $display("FAIL b2b_idle wr/rdy/busy=%b want 010", {st_wr, snp_ready, busy});
    end
  endtask

  initial begin
    rst = 1'b1; snp_valid = 1'b0; snp_msg = '0; lk_ack = 1'b0; lk_state = INVALID;
    sr_ready = 1'b0; l1_ready = 1'b0; wb_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    test_reset();
    test_read_modified();
    test_rwim_stall();
    test_invalidate_exclusive();
    test_self_snoop();
    test_bad_opcode();
    test_reset_mid_wb();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, vectors=%0d", nvec);
    $fatal(1);
  end

endmodule

`default_nettype wire
